// File: rtl/lau_pkg.sv
// -----------------------------------------------------------------------------
// lau_pkg
// Shared types for the carry-propagate back end of the multi-operand adder.
//   csa_resolver_state_e : control states of csa_resolver
//                          (IDLE -> ADD -> DONE -> IDLE).
// -----------------------------------------------------------------------------
package lau_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_resolver_state_e;

endpackage

// File: rtl/csa_chunk_add.sv
// -----------------------------------------------------------------------------
// csa_chunk_add
// Purely combinational chunk-wide ripple-carry adder built from full_adder
// cells. csa_resolver feeds it one chunk of the latched carry-save pair per
// cycle.
// Parameters:
//   chunk  adder width in bits
// Ports:
//   A, B  in  [chunk-1:0] addends
//   CI    in  carry in
//   S     out [chunk-1:0] sum
//   CO    out carry out of bit chunk-1
// -----------------------------------------------------------------------------
module csa_chunk_add #(
    parameter int chunk = 8
) (
    input  logic [chunk-1:0] A,
    input  logic [chunk-1:0] B,
    input  logic             CI,
    output logic [chunk-1:0] S,
    output logic             CO
);

    logic [chunk:0] w_carry;

    assign w_carry[0] = CI;

    for (genvar i = 0; i < chunk; i++) begin : g_fa
        full_adder u_fa (
            .A  (A[i]),
            .B  (B[i]),
            .CI (w_carry[i]),
            .S  (S[i]),
            .CO (w_carry[i+1])
        );
    end

    assign CO = w_carry[chunk];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell, the ripple element of csa_chunk_add.
// Ports:
//   A, B  in  addend bits
//   CI    in  carry in
//   S     out sum bit
//   CO    out carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/csa_resolver.sv
// -----------------------------------------------------------------------------
// csa_resolver
// Sequential carry-propagate back end for carry-save (S,C) pairs. A pair is
// accepted over a valid/ready handshake, resolved to (S+C) mod 2^width one
// chunk per cycle with a registered inter-chunk carry, and returned over a
// second valid/ready handshake. Throughput is one result per NCHUNK+2 cycles.
//
// Optional build macro:
//   CSA_RESOLVER_EARLY_EXIT_EN  finish early once the outgoing chunk carry is
//                               0 and no latched C bit remains above the
//                               current chunk (latency 1..NCHUNK cycles).
//
// Parameters:
//   width  operand/result width (>= 2)
//   chunk  bits resolved per cycle (1 <= chunk <= width)
// Ports:
//   CLK        in  clock, rising edge
//   RST        in  asynchronous reset, active-high
//   IN_VALID   in  carry-save pair present
//   IN_READY   out block can accept a pair (registered)
//   S          in  [width-1:0] sum vector
//   C          in  [width-1:0] weight-aligned carry vector
//   OUT_VALID  out result present
//   OUT_READY  in  consumer takes result
//   Z          out [width-1:0] (S+C) mod 2^width, valid while OUT_VALID=1
//   CO         out carry out of bit width-1
// -----------------------------------------------------------------------------
module csa_resolver
    import lau_pkg::*;
#(
    parameter int width = 32,
    parameter int chunk = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [width-1:0] S,
    input  logic [width-1:0] C,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [width-1:0] Z,
    output logic             CO
);

    localparam int NCHUNK = (width + chunk - 1) / chunk;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Number of real bits in the last chunk; the rest of it is zero padding.
    localparam int LASTW  = width - (NCHUNK - 1) * chunk;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    csa_resolver_state_e r_state;
    logic [width-1:0]    r_s;
    logic [width-1:0]    r_c;
    logic [width-1:0]    r_z;
    logic                r_co;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [chunk-1:0]    w_a;
    logic [chunk-1:0]    w_b;
    logic [chunk-1:0]    w_sum;
    logic                w_co;
    logic                w_last_co;
    logic                w_chunk_co;
    logic [width-1:0]    w_z_next;

    // Select the current chunk of the latched operands; bits past width-1
    // stay zero, which pads the partial last chunk.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < width; i++) begin
            if (r_idx == IDX_W'(i / chunk)) begin
                w_a[i % chunk] = r_s[i];
                w_b[i % chunk] = r_c[i];
            end
        end
    end

    csa_chunk_add #(
        .chunk (chunk)
    ) u_chunk_add (
        .A  (w_a),
        .B  (w_b),
        .CI (r_carry),
        .S  (w_sum),
        .CO (w_co)
    );

    // With a partial last chunk the carry out of bit width-1 lands in the
    // first padding position of the adder sum, not on its CO.
    if (LASTW == chunk) begin : g_last_full
        assign w_last_co = w_co;
    end else begin : g_last_part
        assign w_last_co = w_sum[LASTW];
    end

    assign w_chunk_co = (r_idx == LAST_IDX) ? w_last_co : w_co;

    // Result with the current chunk merged in.
    always_comb begin
        w_z_next = r_z;
        for (int i = 0; i < width; i++) begin
            if (r_idx == IDX_W'(i / chunk)) begin
                w_z_next[i] = w_sum[i % chunk];
            end
        end
    end

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    logic             w_upper_c;
    logic [width-1:0] w_z_exit;
    logic             w_exit;

    // Once no carry leaves this chunk and no C bit remains above it, the
    // upper result bits are exactly the latched S bits.
    always_comb begin
        w_upper_c = 1'b0;
        w_z_exit  = w_z_next;
        for (int i = 0; i < width; i++) begin
            if (IDX_W'(i / chunk) > r_idx) begin
                w_upper_c   = w_upper_c | r_c[i];
                w_z_exit[i] = r_s[i];
            end
        end
    end

    assign w_exit = !w_chunk_co && !w_upper_c;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_z         <= '0;
            r_co        <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_s        <= S;
                        r_c        <= C;
                        r_z        <= '0;
                        r_co       <= 1'b0;
                        r_carry    <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_z     <= w_z_next;
                    r_carry <= w_chunk_co;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_co        <= w_chunk_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
                    if (w_exit) begin
                        r_z         <= w_z_exit;
                        r_co        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
`endif
                end
                DONE: begin
                    // Hand-off returns to IDLE; the next pair is taken no
                    // earlier than the following edge.
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign Z         = r_z;
    assign CO        = r_co;

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Sequential carry-propagate back end for carry-save results, e.g. the (S,C) output vectors of a row of (m,2)-compressors.
- Accepts one carry-save pair per transaction over valid/ready and resolves it to a binary sum CHUNK bits per cycle, with a registered inter-chunk carry.
- Returns the binary result over a second valid/ready handshake.
- Trades latency for area against a full-width fast adder; sits between the multi-operand CSA array and downstream registers.

Parameters:
width, 32, operand and result width in bits (>= 2)
chunk, 8, bits resolved per cycle (1 <= chunk <= width)
NCHUNK, ceil(width/chunk), derived localparam, number of ADD cycles

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
IN_VALID  in  1  carry-save pair present
IN_READY  out  1  block can accept a pair
S  in  width  sum vector
C  in  width  carry vector, already weight-aligned by the caller (bit i has weight 2^i)
OUT_VALID  out  1  result present
OUT_READY  in  1  consumer takes result
Z  out  width  binary result, (S+C) mod 2^width
CO  out  1  carry out of bit width-1

Behaviour:
- Reset (async, RST=1): state=IDLE, IN_READY=1, OUT_VALID=0, Z=0, CO=0, chunk index=0, carry reg=0, operand regs=0. Reset mid-transaction aborts it; no output is produced.
- FSM states IDLE, ADD, DONE (enum in lau_pkg).
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch S,C; idx=0; carry=0; -> ADD.
  - IN_READY is registered state, not combinationally dependent on OUT_READY.
- ADD:
  - IN_READY=0.
  - Each cycle: Z[idx chunk] <= S_chunk + C_chunk + carry; carry <= chunk carry-out; idx++.
  - The last chunk may be partial (width mod chunk bits). Its carry-out comes from bit width-1 and goes to CO.
  - When idx==NCHUNK-1, -> DONE.
- DONE:
  - OUT_VALID=1; Z and CO stable while OUT_VALID=1 and OUT_READY=0.
  - On OUT_READY: -> IDLE, OUT_VALID<=0.
  - A new pair is not accepted in the same cycle as output handoff; throughput is one result per NCHUNK+2 cycles.
- Latency: OUT_VALID rises exactly NCHUNK cycles after the accept edge.
- chunk==width: single ADD cycle.
- IN_VALID is ignored outside IDLE. S and C may change freely after acceptance.
- Z is cleared to 0 on accept so partial results are never visible as stale data. Z is only meaningful while OUT_VALID=1.

Optional Feature:
- Macro: CSA_RESOLVER_EARLY_EXIT_EN.
- When defined, ADD also checks the early-exit condition after writing chunk idx. The condition is: the outgoing carry is 0 and all latched C bits above chunk idx are 0.
- If the condition holds: remaining Z chunks <= remaining latched S bits in the same cycle, CO<=0, -> DONE. Latency varies from 1 to NCHUNK cycles.
- When undefined: fixed NCHUNK latency, no comparator logic.

Decomposition:
- lau_pkg gains csa_resolver_state_e {IDLE, ADD, DONE}.
- NCHUNK is a local derived constant.
- One sub-module, csa_chunk_add:
  - Purely combinational.
  - Inputs: chunk-wide A, B, CI. Outputs: chunk-wide S, CO.
  - Ripple of FullAdder instances.
  - Instantiated once; the partial last chunk is zero-padded.

Test Plan:
- width=32, chunk=8: S=0x0000_00FF, C=0x0000_0001 -> after 4 cycles OUT_VALID=1, Z=0x0000_0100, CO=0; the carry propagates across the chunk boundary.
- width=32, chunk=8: S=0xFFFF_FFFF, C=0x0000_0001 -> Z=0x0000_0000, CO=1; the carry ripples through all 4 chunks.
- width=12, chunk=5 (partial last chunk, NCHUNK=3): S=0xABC, C=0x544 -> Z=0x000, CO=1, latency 3.
- Backpressure: hold OUT_READY=0 for 10 cycles in DONE -> Z, CO and OUT_VALID stay constant and IN_READY=0; the same result is handed off once OUT_READY=1, then IN_READY=1 the next cycle.
- Assert RST during the second ADD cycle -> OUT_VALID=0, Z=0, IN_READY=1 immediately; the next transaction S=5, C=3 -> Z=8.
- CSA_RESOLVER_EARLY_EXIT_EN defined, width=32, chunk=8: S=0x1234_5600, C=0x0000_0001 -> OUT_VALID after 1 cycle, Z=0x1234_5601, CO=0.
- Random S/C sweep against the reference model (S+C) with the macro both on and off.
